// File: rtl/uart_pkg.sv
// Shared UART definitions: configuration field encodings, receiver FSM states
// and small decode helpers used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DIV_W  = 20;
    localparam int WORD_W = 9;

    typedef enum logic [1:0] {
        DATA_7    = 2'd0,
        DATA_8    = 2'd1,
        DATA_9    = 2'd2,
        DATA_RSVD = 2'd3
    } data_type_e;

    typedef enum logic {
        STOP_1 = 1'b0,
        STOP_2 = 1'b1
    } stop_type_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } parity_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    // Reserved data type decodes as 8 bits.
    function automatic logic [3:0] data_len(input logic [1:0] dt);
        case (dt)
            DATA_7:  return 4'd7;
            DATA_9:  return 4'd9;
            default: return 4'd8;
        endcase
    endfunction

    // Reserved parity type decodes as no parity.
    function automatic parity_type_e parity_norm(input logic [1:0] pt);
        if (pt == PAR_RSVD) begin
            return PAR_NONE;
        end
        return parity_type_e'(pt);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the serial line plus a falling-edge detector
// that only fires once a genuinely sampled high has been seen after reset.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_async,
    output logic rx_sync,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic [SYNC_STAGES-1:0] fill_reg;
    logic [SYNC_STAGES-1:0] fill_next;
    logic                   prev_high_reg;
    logic                   last_real;

    // fill_reg marks which stages hold real line samples rather than the preset.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = rx_async;
                assign fill_next[gi] = 1'b1;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
                assign fill_next[gi] = fill_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg      <= '1;
            fill_reg      <= '0;
            prev_high_reg <= 1'b0;
        end else begin
            sync_reg      <= sync_next;
            fill_reg      <= fill_next;
            prev_high_reg <= last_real & sync_reg[SYNC_STAGES-1];
        end
    end

    assign last_real = fill_reg[SYNC_STAGES-1];
    assign rx_sync   = sync_reg[SYNC_STAGES-1];
    assign rx_fall   = last_real & prev_high_reg & ~sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: configurable word length, parity and stop bits, mid-bit
// sampling from a bit-period counter, and a valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  io_config_dataType,
    input  logic        io_config_stopType,
    input  logic [1:0]  io_config_parityType,
    input  logic [19:0] io_config_clockDivider,
    input  logic        io_rx,
    output logic        io_data_valid,
    output logic [8:0]  io_data_bits,
    input  logic        io_data_ready,
    output logic        io_err_parity,
    output logic        io_err_frame,
    output logic        io_err_overrun
);

    logic rx_sync;
    logic rx_fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx_async(io_rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    uart_state_e        state_reg, state_next;
    logic [DIV_W-1:0]   cnt_reg, cnt_next;
    logic [3:0]         bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0]  shift_data_reg, shift_data_next;
    logic [3:0]         cfg_len_reg, cfg_len_next;
    logic               cfg_stop2_reg, cfg_stop2_next;
    parity_type_e       cfg_parity_reg, cfg_parity_next;
    logic [DIV_W-1:0]   cfg_div_reg, cfg_div_next;
    logic               done_reg, done_next;
    logic               frame_err_reg, frame_err_next;
    logic               parity_err_reg, parity_err_next;

    logic               valid_reg, valid_next;
    logic [WORD_W-1:0]  bits_reg, bits_next;
    logic               err_parity_reg, err_parity_next;
    logic               err_frame_reg, err_frame_next;
    logic               err_overrun_reg, err_overrun_next;

    logic               tick;
    logic               parity_ones;

    assign tick        = (cnt_reg == '0);
    assign parity_ones = (^shift_data_reg) ^ rx_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            bit_cnt_reg     <= '0;
            shift_data_reg  <= '0;
            cfg_len_reg     <= 4'd8;
            cfg_stop2_reg   <= 1'b0;
            cfg_parity_reg  <= PAR_NONE;
            cfg_div_reg     <= '0;
            done_reg        <= 1'b0;
            frame_err_reg   <= 1'b0;
            parity_err_reg  <= 1'b0;
            valid_reg       <= 1'b0;
            bits_reg        <= '0;
            err_parity_reg  <= 1'b0;
            err_frame_reg   <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            shift_data_reg  <= shift_data_next;
            cfg_len_reg     <= cfg_len_next;
            cfg_stop2_reg   <= cfg_stop2_next;
            cfg_parity_reg  <= cfg_parity_next;
            cfg_div_reg     <= cfg_div_next;
            done_reg        <= done_next;
            frame_err_reg   <= frame_err_next;
            parity_err_reg  <= parity_err_next;
            valid_reg       <= valid_next;
            bits_reg        <= bits_next;
            err_parity_reg  <= err_parity_next;
            err_frame_reg   <= err_frame_next;
            err_overrun_reg <= err_overrun_next;
        end
    end

    // Frame FSM: every state but IDLE samples the line when the counter expires.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_data_next = shift_data_reg;
        cfg_len_next    = cfg_len_reg;
        cfg_stop2_next  = cfg_stop2_reg;
        cfg_parity_next = cfg_parity_reg;
        cfg_div_next    = cfg_div_reg;
        done_next       = 1'b0;
        frame_err_next  = frame_err_reg;
        parity_err_next = parity_err_reg;

        if (state_reg != ST_IDLE) begin
            cnt_next = tick ? cfg_div_reg : cnt_reg - 20'd1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (rx_fall) begin
                    cfg_len_next    = data_len(io_config_dataType);
                    cfg_stop2_next  = io_config_stopType;
                    cfg_parity_next = parity_norm(io_config_parityType);
                    cfg_div_next    = io_config_clockDivider;
                    cnt_next        = io_config_clockDivider >> 1;
                    bit_cnt_next    = '0;
                    shift_data_next = '0;
                    frame_err_next  = 1'b0;
                    parity_err_next = 1'b0;
                    state_next      = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_data_next[bit_cnt_reg] = rx_sync;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == cfg_len_reg - 4'd1) begin
                        state_next = (cfg_parity_reg == PAR_NONE) ? ST_STOP1 : ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    parity_err_next = parity_ones != (cfg_parity_reg == PAR_ODD);
                    state_next      = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (tick) begin
                    frame_err_next = ~rx_sync;
                    if (cfg_stop2_reg) begin
                        state_next = ST_STOP2;
                    end else begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            ST_STOP2: begin
                if (tick) begin
                    frame_err_next = frame_err_reg | ~rx_sync;
                    state_next     = ST_IDLE;
                    done_next      = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Result stage: frame error wins over parity; a handshake in the same
    // cycle frees the holding register so the new word does not overrun.
    always_comb begin
        valid_next       = valid_reg;
        bits_next        = bits_reg;
        err_parity_next  = 1'b0;
        err_frame_next   = 1'b0;
        err_overrun_next = 1'b0;

        if (valid_reg && io_data_ready) begin
            valid_next = 1'b0;
        end

        if (done_reg) begin
            if (frame_err_reg) begin
                err_frame_next = 1'b1;
            end else if (parity_err_reg) begin
                err_parity_next = 1'b1;
            end else if (!valid_reg || io_data_ready) begin
                valid_next = 1'b1;
                bits_next  = shift_data_reg;
            end else begin
                err_overrun_next = 1'b1;
            end
        end
    end

    assign io_data_valid  = valid_reg;
    assign io_data_bits   = bits_reg;
    assign io_err_parity  = err_parity_reg;
    assign io_err_frame   = err_frame_reg;
    assign io_err_overrun = err_overrun_reg;

endmodule
